// File: rtl/usb_rx_bit_timer.sv
// rtl/usb_rx_bit_timer.sv - USB full-speed RX bit timing, NRZI decode and bit-unstuffing
module usb_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 5,
  parameter int SAMPLE_PHASE = 2,
  parameter int STUFF_LEN    = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic rcving,
  input  logic d_plus_sync,
  input  logic d_minus_sync,
  output logic shift_enable,
  output logic d_orig,
  output logic byte_received,
  output logic eop,
  output logic stuff_error
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_PHASE);
  localparam logic [2:0]    ONES_MAX     = 3'(STUFF_LEN);

  logic [PW-1:0] phase, phase_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [2:0]    ones_cnt, ones_cnt_nxt;
  logic          dp_prev;
  logic          dp_last_sample, dp_last_nxt;
  logic          shift_q, d_orig_q, byte_q, eop_q, err_q;
  logic          shift_nxt, d_orig_nxt, byte_nxt, eop_nxt, err_nxt;
  logic          line_edge, sample, se0, raw;

  // Phase tracking, sampling decision, NRZI decode, unstuffing and byte counting
  always_comb begin
    line_edge    = rcving & (d_plus_sync != dp_prev);
    sample       = rcving & (phase == PHASE_SAMPLE);
    se0          = ~d_plus_sync & ~d_minus_sync;
    // A bit with no line transition since the previous sample decodes as 1
    raw          = (d_plus_sync == dp_last_sample);

    phase_nxt    = phase;
    bit_cnt_nxt  = bit_cnt;
    ones_cnt_nxt = ones_cnt;
    dp_last_nxt  = dp_last_sample;
    shift_nxt    = 1'b0;
    d_orig_nxt   = 1'b0;
    byte_nxt     = 1'b0;
    eop_nxt      = 1'b0;
    err_nxt      = 1'b0;

    // Any line transition re-phases the bit clock; it wins over rollover
    if (line_edge) begin
      phase_nxt = PW'(1);
    end else if (phase == PHASE_LAST) begin
      phase_nxt = '0;
    end else begin
      phase_nxt = phase + PW'(1);
    end

    if (sample) begin
      if (se0) begin
        eop_nxt = 1'b1;
      end else begin
        dp_last_nxt = d_plus_sync;
        if (ones_cnt == ONES_MAX) begin
          // Stuffed 0 is dropped silently; a 1 here breaks the stuffing rule
          ones_cnt_nxt = 3'd0;
          err_nxt      = raw;
        end else begin
          shift_nxt    = 1'b1;
          d_orig_nxt   = raw;
          ones_cnt_nxt = raw ? (ones_cnt + 3'd1) : 3'd0;
          bit_cnt_nxt  = bit_cnt + 3'd1;
          byte_nxt     = (bit_cnt == 3'd7);
        end
      end
    end
  end

  // State and strobe registers; rcving low holds everything at its idle value
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase          <= '0;
      bit_cnt        <= 3'd0;
      ones_cnt       <= 3'd0;
      dp_prev        <= 1'b1;
      dp_last_sample <= 1'b1;
      shift_q        <= 1'b0;
      d_orig_q       <= 1'b0;
      byte_q         <= 1'b0;
      eop_q          <= 1'b0;
      err_q          <= 1'b0;
    end else if (!rcving) begin
      phase          <= '0;
      bit_cnt        <= 3'd0;
      ones_cnt       <= 3'd0;
      dp_prev        <= 1'b1;
      dp_last_sample <= 1'b1;
      shift_q        <= 1'b0;
      d_orig_q       <= 1'b0;
      byte_q         <= 1'b0;
      eop_q          <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      phase          <= phase_nxt;
      bit_cnt        <= bit_cnt_nxt;
      ones_cnt       <= ones_cnt_nxt;
      dp_prev        <= d_plus_sync;
      dp_last_sample <= dp_last_nxt;
      shift_q        <= shift_nxt;
      d_orig_q       <= d_orig_nxt;
      byte_q         <= byte_nxt;
      eop_q          <= eop_nxt;
      err_q          <= err_nxt;
    end
  end

  // Dropping rcving silences any strobe already registered for this cycle
  assign shift_enable  = shift_q  & rcving;
  assign d_orig        = d_orig_q & rcving;
  assign byte_received = byte_q   & rcving;
  assign eop           = eop_q    & rcving;
  assign stuff_error   = err_q    & rcving;

endmodule
